axo_mem_responder: RTL
======================

Name: axo_mem_responder

Overview:
- Bus responder (memory target) for the rv32 core's two initiator buses: data bus (mem_*) and instruction fetch bus (prog_*).
- Backs both buses with one shared word-organised RAM: data port read/write, fetch port read-only.
- Per-port wait-state counter drives a registered one-cycle ready pulse.
- Replaces tied-off ready/data in sim tops; synthesisable for FPGA bring-up.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words (power of two).
- BASE, 32'h0000_0000, byte address mapped to word 0.
- MEM_WAIT, 1, idle cycles before data-port ready (0..15).
- PROG_WAIT, 0, idle cycles before fetch-port ready (0..15).
- INIT_FILE, "", hex image loaded with $readmemh at elaboration when non-empty.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_re  in  1  data read request.
- mem_we  in  1  data write request.
- mem_asize  in  2  0=byte, 1=half, 2=word, 3=reserved.
- mem_ready  out  1  one-cycle completion pulse.
- mem_addr  in  32  byte address.
- mem_data  inout  32  write data from core, or read data to core; right-aligned.
- prog_re  in  1  fetch request.
- prog_ready  out  1  one-cycle completion pulse.
- prog_addr  in  32  byte address; bits [1:0] must be 0.
- prog_data  out  32  fetched word.

Behaviour:
- Reset (async assert, sync deassert inside core): mem_ready=0, prog_ready=0, prog_data=0, mem_data high-Z, both FSMs IDLE, counters 0. RAM contents are kept.
- Per-port FSM states and transitions:
  - IDLE: on request (re or we), load counter=WAIT; go to WAIT, or to DONE if WAIT=0.
  - WAIT: decrement each cycle; when counter reaches 1, go to DONE.
  - DONE: ready=1 for exactly one cycle; perform the write, or register read data; next state IDLE.
  - Request-to-ready latency is WAIT+1 cycles.
- Initiator holds re/we, addr, asize and write data stable until ready.
  - Request dropped before DONE: return to IDLE next cycle; no ready, no write.
  - A new request is accepted no earlier than the cycle after ready (IDLE).
- Address decode: off = addr - BASE; word index = off[31:2].
  - Out of range when off[31:2] >= DEPTH.
  - Misaligned when half access has addr[0]=1, or word access has addr[1:0]!=0.
  - asize=3 is an error.
  - Any error: ready still pulses, write suppressed, read returns 0.
- Read: byte/half extracted by addr[1:0] and right-aligned into bits [7:0] or [15:0]; upper bits zero (core does sign extension).
- Write: byte/half taken from mem_data[7:0] or [15:0], merged at the addressed lane with byte enables; other bytes untouched.
- Bus drive: mem_data is driven only during a data-port read DONE cycle; high-Z otherwise.
- re and we both high: treated as a write; bus not driven.
- Fetch port: word reads only; addr[1:0]!=0 or out of range returns 32'h0000_0013 (nop).
- prog_data holds its value until the next fetch DONE.
- Same-word collision (data write and fetch DONE in the same cycle): fetch returns the old word.
- Reset asserted mid-access: access abandoned, no write committed.

Optional Feature:
- Macro AXO_MEM_ERR_EN.
- Defined: adds outputs mem_err and prog_err (1 bit each). Each pulses together with its ready when that access hit an error condition; reset value 0.
- Undefined: ports absent; errors are silent with the behaviour above.

Decomposition:
- Package axo_mem_pkg:
  - asize_t enum (AXO_SIZE_B/H/W/RSV).
  - port_state_t enum (IDLE/WAIT/DONE).
  - PROG_NOP constant 32'h0000_0013.
  - Function lane_mask(asize, addr[1:0]) returning a 4-bit byte enable.
- Sub-module axo_mem_port_fsm (params WAIT; in req, abort; out ready, done_stb), instantiated once per port. RAM and lane logic stay in the top.

Test Plan:
- MEM_WAIT=1: word write 0xDEADBEEF @0x10, then word read @0x10 -> ready 2 cycles after each request; read returns 0xDEADBEEF.
- Byte write 0xA5 @0x13 over 0xDEADBEEF, then word read @0x10 -> 0xA5ADBEEF; byte read @0x13 -> 0x000000A5.
- Half read @0x11 -> ready pulses, data 0; mem_err=1 with AXO_MEM_ERR_EN; word @0x10 unchanged after a half write @0x11.
- PROG_WAIT=0, INIT_FILE preloaded word0=0x00308093: prog_re @0x0 -> prog_ready next cycle, prog_data=0x00308093; fetch @0x2 -> 0x00000013.
- Data write 0x11111111 @0x20 completing in the same cycle as a fetch @0x20 holding 0x22222222 -> fetch returns 0x22222222; following fetch returns 0x11111111.
- mem_re dropped after 1 cycle with MEM_WAIT=3, and separately rst_n pulsed low mid-write -> no ready, RAM unchanged, FSM back to IDLE and accepts the next request.

Source files
------------

// File: rtl/axo_mem_pkg.sv
// Shared types and helpers for the axo_mem_responder bus target.
package axo_mem_pkg;

   // Access size encoding on mem_asize.
   typedef enum logic [1:0] {
      AXO_SIZE_B   = 2'd0,
      AXO_SIZE_H   = 2'd1,
      AXO_SIZE_W   = 2'd2,
      AXO_SIZE_RSV = 2'd3
   } asize_t;

   // Per-port handshake state.
   typedef enum logic [1:0] {
      PS_IDLE,
      PS_WAIT,
      PS_DONE
   } port_state_t;

   // Returned on the fetch port for any bad fetch address (addi x0,x0,0).
   localparam logic [31:0] PROG_NOP = 32'h0000_0013;

   // Byte enables for an access of the given size at the given byte lane.
   function automatic logic [3:0] lane_mask(asize_t size, logic [1:0] lane);
      case (size)
         AXO_SIZE_B: lane_mask = 4'b0001 << lane;
         AXO_SIZE_H: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
         AXO_SIZE_W: lane_mask = 4'b1111;
         default:    lane_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/axo_mem_port_fsm.sv
// Wait-state handshake for one bus port: IDLE -> WAIT -> DONE -> IDLE.
// done_stb marks the clock edge on which the access commits (entry to DONE);
// ready is the registered one-cycle pulse seen by the initiator during DONE.
module axo_mem_port_fsm
   import axo_mem_pkg::*;
#(
   parameter int WAIT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic abort,
   output logic ready,
   output logic done_stb
);

   port_state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ready_q, ready_d;

   // Next-state, wait counter and commit strobe.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_stb = 1'b0;
      case (state_q)
         PS_IDLE: begin
            if (req) begin
               if (WAIT == 0) begin
                  state_d  = PS_DONE;
                  done_stb = 1'b1;
               end else begin
                  state_d = PS_WAIT;
                  cnt_d   = 4'(WAIT);
               end
            end
         end
         PS_WAIT: begin
            if (abort) begin
               state_d = PS_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q <= 4'd1) begin
               state_d  = PS_DONE;
               cnt_d    = 4'd0;
               done_stb = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = PS_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      ready_d = (state_d == PS_DONE);
   end

   // State, counter and registered ready.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PS_IDLE;
         cnt_q   <= 4'd0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   assign ready = ready_q;

endmodule

// File: rtl/axo_mem_responder.sv
// Memory target for the rv32 data bus (mem_*) and fetch bus (prog_*),
// both backed by one word-organised RAM. Define AXO_MEM_ERR_EN to add the
// mem_err / prog_err error pulse outputs.
module axo_mem_responder
   import axo_mem_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE      = 32'h0000_0000,
   parameter int          MEM_WAIT  = 1,
   parameter int          PROG_WAIT = 0,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_re,
   input  logic        mem_we,
   input  logic [1:0]  mem_asize,
   output logic        mem_ready,
`ifdef AXO_MEM_ERR_EN
   output logic        mem_err,
   output logic        prog_err,
`endif
   input  logic [31:0] mem_addr,
   inout  wire  [31:0] mem_data,
   input  logic        prog_re,
   output logic        prog_ready,
   input  logic [31:0] prog_addr,
   output logic [31:0] prog_data
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] ram [DEPTH];

   // ---------------- data port ----------------
   logic          mem_req, mem_done;
   asize_t        mem_size;
   logic [31:0]   mem_off, mem_rword, mem_rshift, mem_rd, mem_wrep, mem_wmerge;
   logic [AW-1:0] mem_idx;
   logic [3:0]    mem_mask;
   logic          mem_bad, mem_wr_en;
   logic [31:0]   mem_rdata_q, mem_rdata_d;
   logic          mem_drive_q, mem_drive_d;

   assign mem_req = mem_re | mem_we;

   axo_mem_port_fsm #(.WAIT(MEM_WAIT)) u_mem_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (mem_req),
      .abort    (~mem_req),
      .ready    (mem_ready),
      .done_stb (mem_done)
   );

   // Data-port decode, read extraction and write-lane merge.
   always_comb begin
      mem_size  = asize_t'(mem_asize);
      mem_off   = mem_addr - BASE;
      mem_idx   = mem_off[AW+1:2];
      mem_bad   = (mem_off[31:2] >= 30'(DEPTH))
               || (mem_size == AXO_SIZE_RSV)
               || ((mem_size == AXO_SIZE_H) && mem_off[0])
               || ((mem_size == AXO_SIZE_W) && (mem_off[1:0] != 2'b00));
      mem_mask  = lane_mask(mem_size, mem_off[1:0]);
      mem_rword = ram[mem_idx];

      mem_rshift = mem_rword >> {mem_off[1:0], 3'b000};
      case (mem_size)
         AXO_SIZE_B: mem_rd = {24'd0, mem_rshift[7:0]};
         AXO_SIZE_H: mem_rd = {16'd0, mem_rshift[15:0]};
         AXO_SIZE_W: mem_rd = mem_rshift;
         default:    mem_rd = 32'd0;
      endcase
      if (mem_bad) mem_rd = 32'd0;

      case (mem_size)
         AXO_SIZE_B: mem_wrep = {4{mem_data[7:0]}};
         AXO_SIZE_H: mem_wrep = {2{mem_data[15:0]}};
         default:    mem_wrep = mem_data;
      endcase
      mem_wmerge = mem_rword;
      for (int i = 0; i < 4; i++) begin
         if (mem_mask[i]) mem_wmerge[8*i +: 8] = mem_wrep[8*i +: 8];
      end

      // A write wins over a read when both are requested; never commit under reset.
      mem_wr_en   = mem_done && mem_we && !mem_bad && rst_n;
      mem_drive_d = mem_done && mem_re && !mem_we;
      mem_rdata_d = mem_drive_d ? mem_rd : mem_rdata_q;
   end

   assign mem_data = mem_drive_q ? mem_rdata_q : 32'bz;

   // ---------------- fetch port ----------------
   logic          prog_done, prog_bad;
   logic [31:0]   prog_off;
   logic [AW-1:0] prog_idx;
   logic [31:0]   prog_data_q, prog_data_d;

   axo_mem_port_fsm #(.WAIT(PROG_WAIT)) u_prog_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (prog_re),
      .abort    (~prog_re),
      .ready    (prog_ready),
      .done_stb (prog_done)
   );

   // Fetch decode; the word is sampled before any same-edge data write lands.
   always_comb begin
      prog_off    = prog_addr - BASE;
      prog_idx    = prog_off[AW+1:2];
      prog_bad    = (prog_off[31:2] >= 30'(DEPTH)) || (prog_off[1:0] != 2'b00);
      prog_data_d = prog_data_q;
      if (prog_done) prog_data_d = prog_bad ? PROG_NOP : ram[prog_idx];
   end

   assign prog_data = prog_data_q;

   // RAM write port.
   // NOTE: the memory array has no reset; its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_wr_en) ram[mem_idx] <= mem_wmerge;
   end

   // Registered read data and bus-drive enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rdata_q <= 32'd0;
         mem_drive_q <= 1'b0;
         prog_data_q <= 32'd0;
      end else begin
         mem_rdata_q <= mem_rdata_d;
         mem_drive_q <= mem_drive_d;
         prog_data_q <= prog_data_d;
      end
   end

`ifdef AXO_MEM_ERR_EN
   logic mem_err_q, prog_err_q;

   // Error flags pulse alongside ready for accesses that hit a decode error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_err_q  <= 1'b0;
         prog_err_q <= 1'b0;
      end else begin
         mem_err_q  <= mem_done && mem_bad;
         prog_err_q <= prog_done && prog_bad;
      end
   end

   assign mem_err  = mem_err_q;
   assign prog_err = prog_err_q;
`endif

endmodule
